// File: rtl/stc0_pkg.sv
// stc0_pkg: shared definitions for the stc0 Wishbone sequencer.
//   - Wishbone register offsets (decoded from adr[3:2])
//   - STATUS / CTRL bit positions
//   - ingress FSM state type
//   - first_lane(): lowest set bit of a 4-bit byte-select mask
package stc0_pkg;

  localparam logic [1:0] ADR_TXDATA = 2'd0;
  localparam logic [1:0] ADR_RXDATA = 2'd1;
  localparam logic [1:0] ADR_STATUS = 2'd2;
  localparam logic [1:0] ADR_CTRL   = 2'd3;

  // STATUS layout: [7:0] tx_level, [15:8] rx_level, sticky flags above
  localparam int ST_TX_LVL_LSB = 0;
  localparam int ST_RX_LVL_LSB = 8;
  localparam int ST_TX_DROP    = 16;
  localparam int ST_RX_OVF     = 17;
  localparam int ST_BUSY       = 18;

  // CTRL layout
  localparam int CTRL_EN       = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_GAP_LSB  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

  // Returns {found, index} of the lowest set bit in mask.
  function automatic logic [2:0] first_lane(input logic [3:0] mask);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/stc0_wb_seq_if.sv
// stc0_wb_seq_if: Wishbone classic slave bus bundle between the management
// SoC and the stc0 sequencer. Clock and reset stay outside the bundle.
//   wbs_cyc_i / wbs_stb_i / wbs_we_i  cycle, strobe, write enable
//   wbs_sel_i [3:0]                   byte selects
//   wbs_adr_i [31:0]                  address (only [3:2] decoded)
//   wbs_dat_i [31:0]                  write data
//   wbs_dat_o [31:0]                  read data
//   wbs_ack_o                         single-cycle acknowledge
interface stc0_wb_seq_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/stc0_sync_fifo.sv
// stc0_sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst   clock, asynchronous active-high reset
//   push, din  write request and data (ignored when full unless popping)
//   pop        read request (ignored when empty)
//   dout       head entry, valid while !empty
//   full, empty, level  occupancy (level saturates at DEPTH)
module stc0_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign level   = level_reg;
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then; the read of the old head happens before the write.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end
endmodule

// File: rtl/stc0_wb_seq.sv
// stc0_wb_seq: Wishbone slave that feeds 32-bit host words to the stc0_core
// ingress one byte at a time and collects egress bytes for host read-back.
//   wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//   wb                   Wishbone slave bundle (stc0_wb_seq_if.slave)
//   id_o, ivalid_o       ingress byte and strobe to stc0_core
//   ed_i, evalid_i       egress byte and strobe from stc0_core
//   irq_o                level interrupt
module stc0_wb_seq
  import stc0_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int GAP_W    = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  stc0_wb_seq_if.slave  wb,
  output logic [7:0]    id_o,
  output logic          ivalid_o,
  input  logic [7:0]    ed_i,
  input  logic          evalid_i,
  output logic          irq_o
);
  localparam int TXL_W = $clog2(TX_DEPTH) + 1;
  localparam int RXL_W = $clog2(RX_DEPTH) + 1;

  // ---------------- bus decode ----------------
  logic        ack_reg;
  logic [31:0] dat_o_reg;
  logic        access, wr, rd;
  logic [1:0]  reg_sel;
  logic [31:0] rd_data;

  assign access  = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_reg;
  assign wr      = access & wb.wbs_we_i;
  assign rd      = access & ~wb.wbs_we_i;
  assign reg_sel = wb.wbs_adr_i[3:2];

  assign wb.wbs_ack_o = ack_reg;
  assign wb.wbs_dat_o = dat_o_reg;

  // ---------------- registers ----------------
  logic             enable_reg;
  logic             irq_en_reg;
  logic [GAP_W-1:0] gap_reg;
  logic             tx_drop_reg;
  logic             rx_ovf_reg;
  logic             irq_reg;

  // ---------------- FIFOs ----------------
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [35:0]      tx_dout;
  logic [TXL_W-1:0] tx_level;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]       rx_dout;
  logic [RXL_W-1:0] rx_level;
  logic             tx_wr, tx_drop_evt, rx_ovf_evt, status_wr;

  assign tx_wr       = wr & (reg_sel == ADR_TXDATA);
  assign tx_push     = tx_wr & (|wb.wbs_sel_i) & ~tx_full;
  assign tx_drop_evt = tx_wr & ((wb.wbs_sel_i == 4'b0000) | tx_full);
  assign rx_pop      = rd & (reg_sel == ADR_RXDATA) & ~rx_empty;
  // A host pop in the same cycle makes room, so a full FIFO still takes the byte.
  assign rx_push     = evalid_i & (~rx_full | rx_pop);
  assign rx_ovf_evt  = evalid_i & rx_full & ~rx_pop;
  assign status_wr   = wr & (reg_sel == ADR_STATUS);

  stc0_sync_fifo #(.W(36), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (tx_push),
    .din   ({wb.wbs_sel_i, wb.wbs_dat_i}),
    .pop   (tx_pop),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  stc0_sync_fifo #(.W(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (rx_push),
    .din   (ed_i),
    .pop   (rx_pop),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  // ---------------- ingress FSM ----------------
  seq_state_t       state_reg, state_next;
  logic [31:0]      word_reg, word_next;
  logic [3:0]       sel_reg, sel_next;
  logic [1:0]       lane_reg, lane_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [2:0]       first_of_new;
  logic [2:0]       next_above;
  logic [7:0]       lane_bytes [4];
  logic [7:0]       id_reg;
  logic             ivalid_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_bytes[gi] = word_reg[8*gi +: 8];
  end

  assign first_of_new = first_lane(tx_dout[35:32]);
  // Only lanes strictly above the current one are candidates.
  assign next_above   = first_lane(sel_reg & (4'b1110 << lane_reg));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg   <= IDLE;
      word_reg    <= '0;
      sel_reg     <= '0;
      lane_reg    <= '0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      word_reg    <= word_next;
      sel_reg     <= sel_next;
      lane_reg    <= lane_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    word_next    = word_reg;
    sel_next     = sel_reg;
    lane_next    = lane_reg;
    gap_cnt_next = gap_cnt_reg;
    tx_pop       = 1'b0;
    case (state_reg)
      IDLE: begin
        // enable is only looked at here, so a started word always completes
        if (enable_reg && !tx_empty) begin
          tx_pop     = 1'b1;
          word_next  = tx_dout[31:0];
          sel_next   = tx_dout[35:32];
          lane_next  = first_of_new[1:0];
          state_next = SEND;
        end
      end
      SEND: begin
        if (next_above[2]) begin
          lane_next = next_above[1:0];
          if (gap_reg != '0) begin
            gap_cnt_next = gap_reg;
            state_next   = GAP;
          end else begin
            state_next   = SEND;
          end
        end else begin
          state_next = IDLE;
        end
      end
      GAP: begin
        gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        if (gap_cnt_reg <= GAP_W'(1)) state_next = SEND;
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobe is registered from the SEND state, so each SEND cycle yields
  // exactly one ivalid_o pulse one cycle later; id_o holds between pulses.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      id_reg     <= '0;
      ivalid_reg <= 1'b0;
    end else begin
      ivalid_reg <= (state_reg == SEND);
      if (state_reg == SEND) id_reg <= lane_bytes[lane_reg];
    end
  end

  assign id_o     = id_reg;
  assign ivalid_o = ivalid_reg;

  // ---------------- read mux ----------------
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      ADR_RXDATA: begin
        if (!rx_empty) rd_data = {23'b0, 1'b1, rx_dout};
      end
      ADR_STATUS: begin
        rd_data[ST_TX_LVL_LSB +: 8] = 8'(tx_level);
        rd_data[ST_RX_LVL_LSB +: 8] = 8'(rx_level);
        rd_data[ST_TX_DROP]         = tx_drop_reg;
        rd_data[ST_RX_OVF]          = rx_ovf_reg;
        rd_data[ST_BUSY]            = (state_reg != IDLE);
      end
      ADR_CTRL: begin
        rd_data[CTRL_EN]                = enable_reg;
        rd_data[CTRL_IRQ_EN]            = irq_en_reg;
        rd_data[CTRL_GAP_LSB +: GAP_W]  = gap_reg;
      end
      default: rd_data = '0;
    endcase
  end

  // ---------------- bus response, CTRL, flags, irq ----------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_reg     <= 1'b0;
      dat_o_reg   <= '0;
      enable_reg  <= 1'b0;
      irq_en_reg  <= 1'b0;
      gap_reg     <= '0;
      tx_drop_reg <= 1'b0;
      rx_ovf_reg  <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      ack_reg   <= access;
      dat_o_reg <= rd ? rd_data : '0;
      if (wr && reg_sel == ADR_CTRL) begin
        enable_reg <= wb.wbs_dat_i[CTRL_EN];
        irq_en_reg <= wb.wbs_dat_i[CTRL_IRQ_EN];
        gap_reg    <= wb.wbs_dat_i[CTRL_GAP_LSB +: GAP_W];
      end
      // A new event in the same cycle as a clear wins, so nothing is lost.
      tx_drop_reg <= tx_drop_evt |
                     (tx_drop_reg & ~(status_wr & wb.wbs_dat_i[ST_TX_DROP]));
      rx_ovf_reg  <= rx_ovf_evt |
                     (rx_ovf_reg & ~(status_wr & wb.wbs_dat_i[ST_RX_OVF]));
      irq_reg     <= irq_en_reg & ((rx_level != '0) | tx_drop_reg | rx_ovf_reg);
    end
  end

  assign irq_o = irq_reg;

  logic unused_adr_bits;
  assign unused_adr_bits = &{1'b0, wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0]};
endmodule

// File: tb/tb_stc0_wb_seq.sv
module tb_stc0_wb_seq;
  import stc0_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ed = '0;
  logic       evalid = 1'b0;
  logic [7:0] id;
  logic       ivalid;
  logic       irq;

  stc0_wb_seq_if wb();

  stc0_wb_seq #(.TX_DEPTH(16), .RX_DEPTH(16), .GAP_W(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (wb),
    .id_o     (id),
    .ivalid_o (ivalid),
    .ed_i     (ed),
    .evalid_i (evalid),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int ack_cycle = 0;
  int last_iv = -1;
  bit last_we = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- reference model state ----------------
  typedef struct { logic [7:0] b; int rel; int abs; } ib_t;     // expected ingress byte
  typedef struct { logic [31:0] d; logic [3:0] s; } tw_t;       // word waiting while disabled
  typedef struct { logic [31:0] v; logic [31:0] m; string nm; } rd_t;

  ib_t        exp_q[$];
  tw_t        hold_q[$];
  rd_t        rd_q[$];
  logic [7:0] rx_q[$];
  bit         m_en = 0, m_irq_en = 0, m_drop = 0, m_ovf = 0;
  int         m_gap = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  // Bytes of a word in ascending lane order; bytes after the first follow the
  // previous one by gap+1 cycles.
  function automatic void expand(logic [31:0] d, logic [3:0] s, int gap, int abs0);
    bit first = 1'b1;
    ib_t e;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) begin
        e.b   = d[8*i +: 8];
        e.rel = first ? -1 : gap + 1;
        e.abs = first ? abs0 : -1;
        exp_q.push_back(e);
        first = 1'b0;
      end
    end
  endfunction

  // ---------------- monitors ----------------
  ib_t mon_e;
  always @(negedge clk) begin
    if (!rst && ivalid) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL ingress_unexpected: got byte 0x%02h, required no strobe", id);
      end else begin
        mon_e = exp_q.pop_front();
        $display("ingress byte 0x%02h @%0d", id, cyc_cnt);
        chk("ingress_byte", {24'b0, id}, {24'b0, mon_e.b});
        if (mon_e.rel >= 0 && last_iv >= 0) chk("ingress_spacing", cyc_cnt - last_iv, mon_e.rel);
        if (mon_e.abs >= 0) chk("ingress_latency", cyc_cnt, mon_e.abs);
      end
      last_iv = cyc_cnt;
    end
  end

  rd_t mon_r;
  always @(negedge clk) begin
    if (!rst && wb.wbs_ack_o && !last_we) begin
      if (rd_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL read_unexpected: got 0x%08h, required no read ack", wb.wbs_dat_o);
      end else begin
        mon_r = rd_q.pop_front();
        $display("read %s 0x%08h", mon_r.nm, wb.wbs_dat_o);
        chk(mon_r.nm, wb.wbs_dat_o & mon_r.m, mon_r.v & mon_r.m);
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic bus(input bit we, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] ev, input logic [31:0] em,
                     input string nm, input bit eg, input logic [7:0] eb);
    @(negedge clk);
    if (!we) rd_q.push_back('{ev, em, nm});
    else $display("write %s 0x%08h sel=%h", nm, d, s);
    last_we = we;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = s;
    wb.wbs_adr_i = {28'h0, a, 2'b00};
    wb.wbs_dat_i = d;
    if (eg) begin ed = eb; evalid = 1'b1; end
    @(posedge clk); #1;
    chk("ack", {31'b0, wb.wbs_ack_o}, 32'd1);
    ack_cycle = cyc_cnt;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    evalid = 1'b0;
    @(posedge clk);
  endtask

  task automatic tx_write(input logic [31:0] d, input logic [3:0] s, input bit timed);
    bus(1'b1, ADR_TXDATA, d, s, '0, '0, "txdata", 1'b0, 8'h0);
    if (s == 4'b0) m_drop = 1'b1;
    else if (!m_en) begin
      if (hold_q.size() < 16) hold_q.push_back('{d, s});
      else m_drop = 1'b1;
    end else expand(d, s, m_gap, timed ? ack_cycle + 2 : -1);
  endtask

  task automatic ctrl_write(input bit en, input bit ie, input int gap);
    tw_t w;
    bus(1'b1, ADR_CTRL, 32'(en) | (32'(ie) << 1) | (32'(gap) << 4), 4'hF, '0, '0,
        "ctrl", 1'b0, 8'h0);
    m_en = en; m_irq_en = ie; m_gap = gap;
    while (en && hold_q.size() != 0) begin
      w = hold_q.pop_front();
      expand(w.d, w.s, gap, -1);
    end
  endtask

  task automatic w1c(input bit clr_drop, input bit clr_ovf);
    bus(1'b1, ADR_STATUS, (32'(clr_ovf) << 17) | (32'(clr_drop) << 16), 4'hF, '0, '0,
        "status_w1c", 1'b0, 8'h0);
    if (clr_drop) m_drop = 1'b0;
    if (clr_ovf)  m_ovf  = 1'b0;
  endtask

  function automatic void rx_model_push(logic [7:0] b);
    if (rx_q.size() < 16) rx_q.push_back(b);
    else m_ovf = 1'b1;
  endfunction

  task automatic egress(input logic [7:0] b);
    @(negedge clk);
    ed = b; evalid = 1'b1;
    @(negedge clk);
    evalid = 1'b0;
    rx_model_push(b);
  endtask

  task automatic rx_read(input bit eg, input logic [7:0] eb);
    logic [31:0] ev;
    ev = '0;
    if (rx_q.size() != 0) ev = {23'b0, 1'b1, rx_q.pop_front()};
    if (eg) rx_model_push(eb);
    bus(1'b0, ADR_RXDATA, '0, 4'hF, ev, 32'hFFFF_FFFF, "rxdata", eg, eb);
  endtask

  task automatic status_read(input bit tx_known);
    logic [31:0] ev, em;
    ev = (32'(m_ovf) << 17) | (32'(m_drop) << 16) | (32'(rx_q.size()) << 8) |
         32'(hold_q.size());
    em = tx_known ? 32'h0007_FFFF : 32'h0003_FF00;
    bus(1'b0, ADR_STATUS, '0, 4'hF, ev, em, "status", 1'b0, 8'h0);
  endtask

  task automatic check_irq(input string nm);
    repeat (2) @(negedge clk);
    chk(nm, {31'b0, irq}, {31'b0, m_irq_en & ((rx_q.size() != 0) | m_drop | m_ovf)});
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin @(negedge clk); i++; end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d bytes pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_room(input int budget);
    int i = 0;
    while (exp_q.size() >= 15 && i < budget) begin @(negedge clk); i++; end
    if (exp_q.size() >= 15) begin
      n_vec++; n_err++;
      $display("FAIL tx_room: got %0d bytes pending, required < 15", exp_q.size());
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = '0;   wb.wbs_adr_i = '0;   wb.wbs_dat_i = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ivalid", {31'b0, ivalid}, 32'd0);
    chk("rst_id", {24'b0, id}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_ack", {31'b0, wb.wbs_ack_o}, 32'd0);
    rst = 1'b0;
    status_read(1'b1);
    bus(1'b0, ADR_CTRL, '0, 4'hF, 32'h0, 32'hFFFF_FFFF, "ctrl_rd", 1'b0, 8'h0);
    rx_read(1'b0, 8'h0);
    bus(1'b0, ADR_TXDATA, '0, 4'hF, 32'h0, 32'hFFFF_FFFF, "txdata_rd", 1'b0, 8'h0);

    // 1: four back-to-back bytes, latency 2 after ack, busy while sending
    ctrl_write(1'b1, 1'b0, 0);
    tx_write(32'h4433_2211, 4'hF, 1'b1);
    bus(1'b0, ADR_STATUS, '0, 4'hF, 32'h0004_0000, 32'h0004_0000, "busy", 1'b0, 8'h0);
    wait_drain(50);
    status_read(1'b1);
    chk("id_hold", {24'b0, id}, 32'h44);

    // 2: gap=2, lanes 0 and 2 only
    ctrl_write(1'b1, 1'b0, 2);
    tx_write(32'hDDCC_BBAA, 4'b0101, 1'b1);
    wait_drain(50);
    repeat (10) @(negedge clk);
    status_read(1'b1);

    // 3: fill while disabled, overflow the TX FIFO, clear, drain
    ctrl_write(1'b0, 1'b0, 0);
    for (int i = 0; i < 17; i++) tx_write($urandom, 4'hF, 1'b0);
    status_read(1'b1);
    w1c(1'b1, 1'b0);
    status_read(1'b1);
    ctrl_write(1'b1, 1'b0, 0);
    wait_drain(400);
    status_read(1'b1);

    // 4: egress bytes, irq, read-back
    ctrl_write(1'b0, 1'b1, 0);
    egress(8'hA5);
    egress(8'h5A);
    check_irq("irq_rx_pending");
    rx_read(1'b0, 8'h0);
    rx_read(1'b0, 8'h0);
    rx_read(1'b0, 8'h0);
    check_irq("irq_rx_empty");

    // 5: RX overflow, then pop coincident with push on a full FIFO
    for (int i = 0; i < 17; i++) egress(8'(8'h30 + i));
    status_read(1'b1);
    w1c(1'b0, 1'b1);
    rx_read(1'b0, 8'h0);
    egress(8'hE1);
    rx_read(1'b1, 8'hE2);
    status_read(1'b1);
    while (rx_q.size() != 0) rx_read(1'b0, 8'h0);
    status_read(1'b1);

    // randomized phases
    for (int p = 0; p < 3; p++) begin
      wait_drain(600);
      ctrl_write(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      for (int k = 0; k < 30; k++) begin
        case ($urandom_range(0, 5))
          0, 1: begin
            wait_room(400);
            tx_write($urandom, 4'($urandom_range(0, 15)), 1'b0);
          end
          2: egress(8'($urandom));
          3: rx_read(1'b0, 8'h0);
          4: status_read(1'b0);
          default: w1c(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        endcase
        if (k % 5 == 4) check_irq("irq_random");
      end
    end
    wait_drain(600);
    status_read(1'b1);
    while (rx_q.size() != 0) rx_read(1'b0, 8'h0);
    w1c(1'b1, 1'b1);
    status_read(1'b1);

    // 6: reset while lane 1 is being sent
    ctrl_write(1'b1, 1'b1, 0);
    egress(8'h77);
    check_irq("irq_before_reset");
    tx_write(32'h0F0E_0D0C, 4'hF, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ivalid) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL first_strobe: got no ivalid_o within 20 cycles, required one");
    end
    #1 rst = 1'b1;
    #1;
    chk("reset_async_ivalid", {31'b0, ivalid}, 32'd0);
    chk("reset_async_irq", {31'b0, irq}, 32'd0);
    exp_q.delete(); hold_q.delete(); rx_q.delete();
    m_en = 0; m_irq_en = 0; m_drop = 0; m_ovf = 0; m_gap = 0; last_iv = -1;
    @(negedge clk);
    rst = 1'b0;
    status_read(1'b1);
    bus(1'b0, ADR_CTRL, '0, 4'hF, 32'h0, 32'hFFFF_FFFF, "ctrl_after_reset", 1'b0, 8'h0);
    repeat (5) @(negedge clk);
    chk("irq_after_reset", {31'b0, irq}, 32'd0);
    chk("ivalid_after_reset", {31'b0, ivalid}, 32'd0);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish within 1 ms");
    $fatal(1);
  end
endmodule
